// File: rtl/char_buf_streamer.sv
// Character-buffer subsystem: COLS x ROWS character RAM, control CSRs, and an Avalon-ST source
// that streams {fg, bg, char} for every cell in raster order, with circular row scroll and a fill engine.
module char_buf_streamer #(
    parameter int COLS    = 80,
    parameter int ROWS    = 60,
    parameter int COLOR_W = 16,
    parameter int DATA_W  = 8 + 2*COLOR_W,
    parameter int DEPTH   = COLS*ROWS/4,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              sys_clk_clk,
    input  logic              sys_reset_reset_n,
    input  logic [ADDR_W-1:0] char_buffer_slave_address,
    input  logic              char_buffer_slave_chipselect,
    input  logic              char_buffer_slave_clken,
    input  logic              char_buffer_slave_write,
    input  logic [3:0]        char_buffer_slave_byteenable,
    input  logic [31:0]       char_buffer_slave_writedata,
    output logic [31:0]       char_buffer_slave_readdata,
    input  logic [1:0]        char_buffer_control_slave_address,
    input  logic              char_buffer_control_slave_read,
    input  logic              char_buffer_control_slave_write,
    input  logic [3:0]        char_buffer_control_slave_byteenable,
    input  logic [31:0]       char_buffer_control_slave_writedata,
    output logic [31:0]       char_buffer_control_slave_readdata,
    input  logic              avalon_char_source_ready,
    output logic              avalon_char_source_valid,
    output logic [DATA_W-1:0] avalon_char_source_data,
    output logic              avalon_char_source_startofpacket,
    output logic              avalon_char_source_endofpacket
);
    localparam int IDX_W = $clog2(COLS*ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int ENT_W = DATA_W + 2;
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

    typedef enum logic {C_IDLE, C_FILL} clr_state_t;
    typedef enum logic {S_IDLE, S_RUN} str_state_t;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return res;
    endfunction

    logic [31:0] mem [DEPTH];

    logic              enable_q, enable_d;
    logic [7:0]        fill_q, fill_d;
    logic [ROW_W-1:0]  scroll_q, scroll_d;
    logic [15:0]       fg_q, fg_d, bg_q, bg_d;
    clr_state_t        clr_st_q, clr_st_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [31:0]       rdata_q, rdata_d;
    str_state_t        st_q, st_d;
    logic [ROW_W-1:0]  row_q, row_d, prow_q, prow_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [15:0]       fgl_q, fgl_d, bgl_q, bgl_d;
    logic              rd_vld_q, rd_vld_d;
    logic [31:0]       rd_word_q, rd_word_d;
    logic [1:0]        rd_byte_q, rd_byte_d;
    logic [33:0]       rd_meta_q, rd_meta_d;
    logic [ENT_W-1:0]  e0_q, e0_d, e1_q, e1_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              valid_q, valid_d;

    logic              clr_req_s, busy_s, slv_wr_s, slv_rd_s, in_range_s;
    logic              mem_we_s, pop_s, issue_s, first_s, last_s;
    logic [3:0]        mem_be_s;
    logic [ADDR_W-1:0] mem_waddr_s, word_s;
    logic [31:0]       mem_wdata_s, scr_new_s, col_new_s;
    logic [IDX_W-1:0]  idx_s;
    logic [2:0]        occ_s;
    logic [1:0]        cnt_tmp_s;
    logic [7:0]        char_s;
    logic [ENT_W-1:0]  push_ent_s;

    // CSR write decode; an out-of-range scroll write leaves the register untouched.
    always_comb begin
        enable_d  = enable_q;
        fill_d    = fill_q;
        scroll_d  = scroll_q;
        fg_d      = fg_q;
        bg_d      = bg_q;
        clr_req_s = 1'b0;
        scr_new_s = be_merge(32'(scroll_q), char_buffer_control_slave_writedata,
                             char_buffer_control_slave_byteenable);
        col_new_s = be_merge({fg_q, bg_q}, char_buffer_control_slave_writedata,
                             char_buffer_control_slave_byteenable);
        if (char_buffer_control_slave_write) begin
            case (char_buffer_control_slave_address)
                2'd0: begin
                    if (char_buffer_control_slave_byteenable[0]) begin
                        enable_d  = char_buffer_control_slave_writedata[0];
                        clr_req_s = char_buffer_control_slave_writedata[1];
                    end else begin
                        enable_d  = enable_q;
                    end
                    if (char_buffer_control_slave_byteenable[1]) begin
                        fill_d = char_buffer_control_slave_writedata[15:8];
                    end else begin
                        fill_d = fill_q;
                    end
                end
                2'd1: begin
                    if (scr_new_s < 32'(ROWS)) scroll_d = ROW_W'(scr_new_s);
                    else                       scroll_d = scroll_q;
                end
                2'd2: begin
                    fg_d = col_new_s[31:16];
                    bg_d = col_new_s[15:0];
                end
                default: enable_d = enable_q;
            endcase
        end else begin
            enable_d = enable_q;
        end
    end

    // Fill engine: one full word per cycle across the whole RAM.
    always_comb begin
        clr_st_d   = clr_st_q;
        clr_addr_d = clr_addr_q;
        case (clr_st_q)
            C_IDLE: begin
                if (clr_req_s) begin
                    clr_st_d   = C_FILL;
                    clr_addr_d = '0;
                end else begin
                    clr_st_d   = C_IDLE;
                end
            end
            C_FILL: begin
                if (clr_addr_q == LAST_WORD) begin
                    clr_st_d   = C_IDLE;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                end
            end
            default: clr_st_d = C_IDLE;
        endcase
    end

    assign busy_s     = (clr_st_q == C_FILL);
    assign in_range_s = (char_buffer_slave_address <= LAST_WORD);
    assign slv_wr_s   = char_buffer_slave_chipselect & char_buffer_slave_clken &
                        char_buffer_slave_write & ~busy_s & in_range_s;
    assign slv_rd_s   = char_buffer_slave_chipselect & char_buffer_slave_clken & ~char_buffer_slave_write;

    // RAM write port arbitration: the fill engine owns the port while busy.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_be_s    = 4'h0;
        mem_waddr_s = char_buffer_slave_address;
        mem_wdata_s = char_buffer_slave_writedata;
        if (busy_s) begin
            mem_we_s    = 1'b1;
            mem_be_s    = 4'hF;
            mem_waddr_s = clr_addr_q;
            mem_wdata_s = {4{fill_q}};
        end else if (slv_wr_s) begin
            mem_we_s    = 1'b1;
            mem_be_s    = char_buffer_slave_byteenable;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Character RAM storage; deliberately not reset.
    always_ff @(posedge sys_clk_clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be_s[b]) mem[mem_waddr_s][8*b +: 8] <= mem_wdata_s[8*b +: 8];
            end
        end
    end

    // Host read path; reads during a fill return zero.
    always_comb begin
        rdata_d = rdata_q;
        if (slv_rd_s) begin
            if (busy_s || !in_range_s) rdata_d = 32'h0;
            else                       rdata_d = mem[char_buffer_slave_address];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read issue: only when the output FIFO is guaranteed a free slot for the returning word.
    always_comb begin
        idx_s     = IDX_W'(prow_q) * IDX_W'(COLS) + IDX_W'(col_q);
        word_s    = ADDR_W'(idx_s >> 2);
        pop_s     = valid_q & avalon_char_source_ready;
        occ_s     = 3'(cnt_q) + 3'(rd_vld_q) - 3'(pop_s);
        issue_s   = (st_q == S_RUN) && (occ_s < 3'd2);
        first_s   = (row_q == '0) && (col_q == '0);
        last_s    = (row_q == LAST_ROW) && (col_q == LAST_COL);
        rd_vld_d  = issue_s;
        rd_word_d = rd_word_q;
        rd_byte_d = rd_byte_q;
        rd_meta_d = rd_meta_q;
        if (issue_s) begin
            rd_word_d = mem[word_s];
            rd_byte_d = idx_s[1:0];
            rd_meta_d = {first_s, last_s, fgl_q, bgl_q};
        end else begin
            rd_word_d = rd_word_q;
        end
    end

    // Stream FSM: walks cells, wraps the physical row, re-latches frame settings at each frame start.
    always_comb begin
        st_d   = st_q;
        row_d  = row_q;
        col_d  = col_q;
        prow_d = prow_q;
        fgl_d  = fgl_q;
        bgl_d  = bgl_q;
        case (st_q)
            S_IDLE: begin
                if (enable_q) begin
                    st_d   = S_RUN;
                    row_d  = '0;
                    col_d  = '0;
                    prow_d = scroll_q;
                    fgl_d  = fg_q;
                    bgl_d  = bg_q;
                end else begin
                    st_d   = S_IDLE;
                end
            end
            S_RUN: begin
                if (issue_s && last_s) begin
                    row_d  = '0;
                    col_d  = '0;
                    prow_d = scroll_q;
                    fgl_d  = fg_q;
                    bgl_d  = bg_q;
                    st_d   = enable_q ? S_RUN : S_IDLE;
                end else if (issue_s && (col_q == LAST_COL)) begin
                    col_d  = '0;
                    row_d  = row_q + ROW_W'(1);
                    prow_d = (prow_q == LAST_ROW) ? '0 : prow_q + ROW_W'(1);
                end else if (issue_s) begin
                    col_d  = col_q + COL_W'(1);
                end else begin
                    st_d   = S_RUN;
                end
            end
            default: st_d = S_IDLE;
        endcase
    end

    // Byte select of the returning word, then two-entry output FIFO with the head driving the port.
    always_comb begin
        case (rd_byte_q)
            2'd0:    char_s = rd_word_q[7:0];
            2'd1:    char_s = rd_word_q[15:8];
            2'd2:    char_s = rd_word_q[23:16];
            default: char_s = rd_word_q[31:24];
        endcase
        push_ent_s = {rd_meta_q[33:32], COLOR_W'(rd_meta_q[31:16]), COLOR_W'(rd_meta_q[15:0]), char_s};
        e0_d = e0_q;
        e1_d = e1_q;
        if (pop_s) begin
            e0_d      = e1_q;
            cnt_tmp_s = cnt_q - 2'd1;
        end else begin
            cnt_tmp_s = cnt_q;
        end
        if (rd_vld_q) begin
            if (cnt_tmp_s == 2'd0) e0_d = push_ent_s;
            else                   e1_d = push_ent_s;
            cnt_d = cnt_tmp_s + 2'd1;
        end else begin
            cnt_d = cnt_tmp_s;
        end
        valid_d = (cnt_d != 2'd0);
    end

    // State registers.
    always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
        if (!sys_reset_reset_n) begin
            enable_q <= 1'b0;      fill_q   <= 8'h20;     scroll_q <= '0;
            fg_q     <= 16'hFFFF;  bg_q     <= 16'h0000;
            clr_st_q <= C_IDLE;    clr_addr_q <= '0;      rdata_q <= 32'h0;
            st_q     <= S_IDLE;    row_q    <= '0;        col_q   <= '0;   prow_q <= '0;
            fgl_q    <= 16'h0;     bgl_q    <= 16'h0;
            rd_vld_q <= 1'b0;      rd_word_q <= 32'h0;    rd_byte_q <= 2'd0; rd_meta_q <= '0;
            e0_q     <= '0;        e1_q     <= '0;        cnt_q   <= 2'd0; valid_q <= 1'b0;
        end else begin
            enable_q <= enable_d;  fill_q   <= fill_d;    scroll_q <= scroll_d;
            fg_q     <= fg_d;      bg_q     <= bg_d;
            clr_st_q <= clr_st_d;  clr_addr_q <= clr_addr_d; rdata_q <= rdata_d;
            st_q     <= st_d;      row_q    <= row_d;     col_q   <= col_d; prow_q <= prow_d;
            fgl_q    <= fgl_d;     bgl_q    <= bgl_d;
            rd_vld_q <= rd_vld_d;  rd_word_q <= rd_word_d; rd_byte_q <= rd_byte_d; rd_meta_q <= rd_meta_d;
            e0_q     <= e0_d;      e1_q     <= e1_d;      cnt_q   <= cnt_d; valid_q <= valid_d;
        end
    end

    // CSR read mux, same-cycle.
    always_comb begin
        char_buffer_control_slave_readdata = 32'h0;
        if (char_buffer_control_slave_read) begin
            case (char_buffer_control_slave_address)
                2'd0:    char_buffer_control_slave_readdata = {16'h0, fill_q, 5'h0, busy_s, 1'b0, enable_q};
                2'd1:    char_buffer_control_slave_readdata = 32'(scroll_q);
                2'd2:    char_buffer_control_slave_readdata = {fg_q, bg_q};
                default: char_buffer_control_slave_readdata = {16'(ROWS), 16'(COLS)};
            endcase
        end else begin
            char_buffer_control_slave_readdata = 32'h0;
        end
    end

    assign char_buffer_slave_readdata       = rdata_q;
    assign avalon_char_source_valid         = valid_q;
    assign avalon_char_source_startofpacket = e0_q[ENT_W-1];
    assign avalon_char_source_endofpacket   = e0_q[ENT_W-2];
    assign avalon_char_source_data          = e0_q[DATA_W-1:0];

endmodule

// File: tb/tb_char_buf_streamer.sv
// Bench for char_buf_streamer: random RAM contents and ready patterns checked against a
// cell-by-cell arithmetic model of the frame stream.
module tb_char_buf_streamer;
    localparam int COLS = 80, ROWS = 60, NCELL = COLS*ROWS, DEPTH = NCELL/4;
    localparam int ADDR_W = 11, DATA_W = 40;

    logic clk = 1'b0;
    logic rst_n;
    logic [ADDR_W-1:0] cb_addr;
    logic cb_cs, cb_clken, cb_write;
    logic [3:0] cb_be;
    logic [31:0] cb_wdata, cb_rdata;
    logic [1:0] ct_addr;
    logic ct_read, ct_write;
    logic [3:0] ct_be;
    logic [31:0] ct_wdata, ct_rdata;
    logic src_ready, valid, sop, eop;
    logic [DATA_W-1:0] data;

    int errors = 0;
    int checks = 0;
    logic [31:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    char_buf_streamer dut (
        .sys_clk_clk(clk), .sys_reset_reset_n(rst_n),
        .char_buffer_slave_address(cb_addr), .char_buffer_slave_chipselect(cb_cs),
        .char_buffer_slave_clken(cb_clken), .char_buffer_slave_write(cb_write),
        .char_buffer_slave_byteenable(cb_be), .char_buffer_slave_writedata(cb_wdata),
        .char_buffer_slave_readdata(cb_rdata),
        .char_buffer_control_slave_address(ct_addr), .char_buffer_control_slave_read(ct_read),
        .char_buffer_control_slave_write(ct_write), .char_buffer_control_slave_byteenable(ct_be),
        .char_buffer_control_slave_writedata(ct_wdata), .char_buffer_control_slave_readdata(ct_rdata),
        .avalon_char_source_ready(src_ready), .avalon_char_source_valid(valid),
        .avalon_char_source_data(data), .avalon_char_source_startofpacket(sop),
        .avalon_char_source_endofpacket(eop)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mem_write(input int a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        cb_addr = ADDR_W'(a); cb_cs = 1'b1; cb_write = 1'b1; cb_be = be; cb_wdata = d;
        @(negedge clk);
        cb_cs = 1'b0; cb_write = 1'b0;
    endtask

    task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic mem_read(input int a, output logic [31:0] d);
        @(negedge clk);
        cb_addr = ADDR_W'(a); cb_cs = 1'b1; cb_write = 1'b0;
        @(negedge clk);
        cb_cs = 1'b0;
        d = cb_rdata;
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        ct_addr = a; ct_write = 1'b1; ct_be = be; ct_wdata = d;
        @(negedge clk);
        ct_write = 1'b0;
    endtask

    task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
        ct_addr = a; ct_read = 1'b1;
        #1;
        d = ct_rdata;
        ct_read = 1'b0;
    endtask

    // Expected beat k of a frame, straight from the scroll/raster rule.
    function automatic logic [41:0] exp_beat(input int k, input int s, input logic [15:0] fg,
                                             input logic [15:0] bg);
        int c, row, col, idx;
        logic [31:0] w;
        c   = k % NCELL;
        row = c / COLS;
        col = c % COLS;
        idx = ((row + s) % ROWS) * COLS + col;
        w   = ref_mem[idx / 4];
        return {c == 0, c == NCELL - 1, fg, bg, w[8*(idx % 4) +: 8]};
    endfunction

    // Accept n beats starting at stream beat k0; frame 0 uses set a, later frames set b.
    task automatic consume(input int k0, input int n, input bit rnd,
                           input int sa, input logic [15:0] fga, input logic [15:0] bga,
                           input int sb, input logic [15:0] fgb, input logic [15:0] bgb);
        int k, got, cyc, gaps;
        bit started, stalled, r;
        logic [41:0] held, obs, expv;
        k = k0; got = 0; cyc = 0; gaps = 0; started = 1'b0; stalled = 1'b0; held = '0;
        while (got < n && cyc < n*4 + 200) begin
            obs = {sop, eop, data};
            if (stalled) check("stall_hold", {valid, obs}, {1'b1, held});
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            src_ready = r;
            if (valid && r) begin
                if (k < NCELL) expv = exp_beat(k, sa, fga, bga);
                else           expv = exp_beat(k, sb, fgb, bgb);
                check($sformatf("beat%0d", k), obs, expv);
                k++; got++;
            end
            if (started && !valid) gaps++;
            if (valid) started = 1'b1;
            stalled = valid && !r;
            held = obs;
            @(negedge clk);
            cyc++;
        end
        src_ready = 1'b0;
        check("beat_count", got, n);
        if (!rnd) check("no_gaps", gaps, 0);
    endtask

    task automatic idle_check(input int n);
        src_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("valid_idle", valid, 1'b0);
        end
        src_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int lat, busy_cnt;
        rst_n = 1'b0; cb_addr = '0; cb_cs = 1'b0; cb_clken = 1'b1; cb_write = 1'b0; cb_be = 4'h0;
        cb_wdata = 32'h0; ct_addr = 2'd0; ct_read = 1'b0; ct_write = 1'b0; ct_be = 4'h0;
        ct_wdata = 32'h0; src_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stream", {valid, sop, eop, data}, 64'h0);
        check("rst_rdata", cb_rdata, 32'h0);
        check("rst_ctl_rdata", ct_rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        csr_read(2'd0, rd); check("ctrl_reset", rd, 32'h0000_2000);
        csr_read(2'd1, rd); check("scroll_reset", rd, 32'h0);
        csr_read(2'd2, rd); check("colour_reset", rd, 32'hFFFF_0000);
        csr_read(2'd3, rd); check("geom", rd, 32'h003C_0050);

        // Host port: basic write/readback, clken hold, byte enables.
        mem_write(0, 32'h4443_4241, 4'hF); model_write(0, 32'h4443_4241, 4'hF);
        mem_read(0, rd); check("word0_readback", rd, 32'h4443_4241);
        @(negedge clk);
        cb_clken = 1'b0; cb_cs = 1'b1; cb_write = 1'b0; cb_addr = ADDR_W'(1);
        @(negedge clk);
        cb_cs = 1'b0; cb_clken = 1'b1;
        check("clken_hold", cb_rdata, 32'h4443_4241);
        for (int w = 1; w < DEPTH; w++) begin
            rd = $urandom;
            mem_write(w, rd, 4'hF); model_write(w, rd, 4'hF);
        end
        mem_write(20, 32'hAABB_CC5A, 4'b0001); model_write(20, 32'hAABB_CC5A, 4'b0001);
        mem_read(20, rd); check("byteen_merge", rd, ref_mem[20]);
        mem_write(0, 32'h4443_4241, 4'hF);
        for (int i = 0; i < 6; i++) begin
            lat = int'($urandom_range(0, DEPTH - 1));
            mem_read(lat, rd); check("rand_readback", rd, ref_mem[lat]);
        end

        // Frame A (scroll 0) then frame B (scroll 1, new colour) back-to-back at full rate.
        csr_write(2'd2, 32'hF800_001F, 4'hF);
        csr_write(2'd0, 32'h0000_0001, 4'b0001);
        lat = 0;
        while (!valid && lat < 10) begin @(negedge clk); lat++; end
        check("first_valid_latency", lat, 3);
        consume(0, 2400, 1'b0, 0, 16'hF800, 16'h001F, 1, 16'h1234, 16'h5678);
        csr_write(2'd2, 32'h1234_5678, 4'hF);
        csr_write(2'd1, 32'd1, 4'h1);
        csr_write(2'd1, 32'd60, 4'h1);
        csr_read(2'd1, rd); check("scroll_oob_dropped", rd, 32'd1);
        consume(2400, 2500, 1'b0, 0, 16'hF800, 16'h001F, 1, 16'h1234, 16'h5678);
        csr_write(2'd0, 32'h0000_2000, 4'b0001);
        consume(4900, 4700, 1'b0, 0, 16'hF800, 16'h001F, 1, 16'h1234, 16'h5678);
        idle_check(20);

        // Frame C with random backpressure.
        csr_write(2'd0, 32'h0000_0001, 4'b0001);
        consume(0, 10, 1'b1, 1, 16'h1234, 16'h5678, 1, 16'h1234, 16'h5678);
        csr_write(2'd0, 32'h0000_0000, 4'b0001);
        consume(10, 4790, 1'b1, 1, 16'h1234, 16'h5678, 1, 16'h1234, 16'h5678);
        idle_check(10);

        // Fill engine: busy length, dropped host write, zero reads, repeat clear ignored.
        csr_write(2'd0, 32'h0000_2E02, 4'b0011);
        busy_cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            csr_read(2'd0, rd);
            if (!rd[2]) break;
            busy_cnt++;
            if (i == 101 || i == 201) begin cb_cs = 1'b0; cb_write = 1'b0; end
            if (i == 301) ct_write = 1'b0;
            if (i == 201) check("read_during_busy", cb_rdata, 32'h0);
            if (i == 100) begin
                cb_addr = ADDR_W'(7); cb_cs = 1'b1; cb_write = 1'b1; cb_be = 4'hF; cb_wdata = 32'h1111_1111;
            end
            if (i == 200) begin cb_addr = ADDR_W'(3); cb_cs = 1'b1; cb_write = 1'b0; end
            if (i == 300) begin ct_addr = 2'd0; ct_write = 1'b1; ct_be = 4'b0011; ct_wdata = 32'h0000_2E02; end
            @(negedge clk);
        end
        ct_write = 1'b0; cb_cs = 1'b0; cb_write = 1'b0;
        check("busy_cycles", busy_cnt, DEPTH);
        csr_read(2'd0, rd); check("ctrl_after_clear", rd, 32'h0000_2E00);
        for (int w = 0; w < DEPTH; w++) ref_mem[w] = 32'h2E2E_2E2E;
        for (int w = 0; w < DEPTH; w++) begin
            mem_read(w, rd); check("fill_word", rd, ref_mem[w]);
        end

        // Enable dropped mid-frame: frame completes, then silence.
        csr_write(2'd0, 32'h0000_0001, 4'b0001);
        consume(0, 100, 1'b0, 1, 16'h1234, 16'h5678, 1, 16'h1234, 16'h5678);
        csr_write(2'd0, 32'h0000_0000, 4'b0001);
        consume(100, 4700, 1'b0, 1, 16'h1234, 16'h5678, 1, 16'h1234, 16'h5678);
        idle_check(20);

        // Reset mid-frame.
        csr_write(2'd0, 32'h0000_0001, 4'b0001);
        consume(0, 50, 1'b0, 1, 16'h1234, 16'h5678, 1, 16'h1234, 16'h5678);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_stream", {valid, sop, eop, data}, 64'h0);
        check("async_reset_rdata", cb_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check(10);
        csr_read(2'd0, rd); check("ctrl_after_reset", rd, 32'h0000_2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
